// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte buffer feeding uart_tx, with level/full/empty and sticky overflow
module uart_tx_fifo #(
    parameter int Depth     = 16,
    parameter int DataWidth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DataWidth-1:0]       wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic                       flush,
    input  logic                       clear_overflow,
    output logic [DataWidth-1:0]       data_out,
    output logic                       data_out_valid,
    input  logic                       tx_ready,
    output logic [$clog2(Depth):0]     level,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);
    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    logic [DataWidth-1:0] mem [Depth];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level_q;
    logic                 overflow_q;
    logic                 push;
    logic                 pop;

    // status outputs depend only on registered level, never on wr_valid/tx_ready
    always_comb begin
        empty          = level_q == '0;
        full           = level_q == LW'(Depth);
        wr_ready       = !full;
        data_out_valid = !empty;
        level          = level_q;
        overflow       = overflow_q;
        data_out       = mem[rd_ptr];
        push           = wr_valid && !full && !flush;
        pop            = tx_ready && !empty && !flush;
    end

    // storage is not reset; only written on an accepted push
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // pointers and level; flush overrides both push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level_q <= (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
        end
    end

    // sticky overflow: a write attempt while full wins over a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else overflow_q <= (wr_valid && full) ? 1'b1 : clear_overflow ? 1'b0 : overflow_q;
    end
endmodule
